// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM states, default width
// and the packed result record used by consumers of the quotient/remainder pair.
package seq_divider_pkg;

  localparam int DEF_DATA_LEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } t_div_state;

  typedef struct packed {
    logic [DEF_DATA_LEN-1:0] quotient;
    logic [DEF_DATA_LEN-1:0] remainder;
    logic                    div_by_zero;
  } t_div_result;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when the result stays non-negative.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic [DATA_LEN:0]   rem_in,
  input  logic                bit_in,
  input  logic [DATA_LEN-1:0] divisor,
  output logic [DATA_LEN:0]   rem_out,
  output logic                q_bit
);

  logic [DATA_LEN:0] shifted;
  logic [DATA_LEN:0] diff;
  // The partial remainder is always below the divisor, so its top bit is zero.
  logic              unused_rem_msb;

  assign unused_rem_msb = rem_in[DATA_LEN];
  assign shifted        = {rem_in[DATA_LEN-1:0], bit_in};
  assign diff           = shifted - {1'b0, divisor};
  assign q_bit          = (shifted >= {1'b0, divisor});
  assign rem_out        = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN to honour op_signed (two's-complement division with a FIX stage).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  input  logic                op_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder,
  output logic                div_by_zero,
  output logic                busy
);

  localparam int CNT_W = (DATA_LEN > 2) ? $clog2(DATA_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);

  t_div_state state_reg, state_next;

  logic [DATA_LEN-1:0] q_reg;
  logic [DATA_LEN-1:0] d_reg;
  logic [DATA_LEN-1:0] a_raw_reg;
  logic [DATA_LEN:0]   r_reg;
  logic [CNT_W-1:0]    cnt_reg;
  // Divide-by-zero takes one extra cycle in DONE to publish its fixed result.
  logic                zero_pend_reg;

  logic [DATA_LEN-1:0] a_mag;
  logic [DATA_LEN-1:0] b_mag;
  logic [DATA_LEN:0]   step_rem;
  logic                step_q;
  logic [DATA_LEN-1:0] q_next;
  logic                fix_needed;
  logic                accept;
  logic                last_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic a_neg, b_neg;
  logic signed_reg;
  logic neg_q_reg;
  logic neg_r_reg;

  assign a_neg      = op_signed & a[DATA_LEN-1];
  assign b_neg      = op_signed & b[DATA_LEN-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign fix_needed = signed_reg;
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign a_mag            = a;
  assign b_mag            = b;
  assign fix_needed       = 1'b0;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE) && !zero_pend_reg;
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_reg == '0);
  assign q_next    = {q_reg[DATA_LEN-2:0], step_q};

  div_step #(
    .DATA_LEN(DATA_LEN)
  ) u_step (
    .rem_in (r_reg),
    .bit_in (q_reg[DATA_LEN-1]),
    .divisor(d_reg),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (b == '0) ? DONE : CALC;
      CALC: if (last_step) state_next = fix_needed ? FIX : DONE;
      FIX:  state_next = DONE;
      DONE: if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      d_reg         <= '0;
      a_raw_reg     <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      zero_pend_reg <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      signed_reg    <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_raw_reg     <= a;
            q_reg         <= a_mag;
            d_reg         <= b_mag;
            r_reg         <= '0;
            cnt_reg       <= CNT_LAST;
            zero_pend_reg <= (b == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
            signed_reg    <= op_signed;
            neg_q_reg     <= a_neg ^ b_neg;
            neg_r_reg     <= a_neg;
`endif
          end
        end
        CALC: begin
          r_reg   <= step_rem;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (last_step && !fix_needed) begin
            quotient    <= q_next;
            remainder   <= step_rem[DATA_LEN-1:0];
            div_by_zero <= 1'b0;
          end
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        FIX: begin
          // Magnitude result is re-signed: quotient truncates toward zero, remainder follows dividend.
          quotient    <= neg_q_reg ? -q_reg : q_reg;
          remainder   <= neg_r_reg ? -r_reg[DATA_LEN-1:0] : r_reg[DATA_LEN-1:0];
          div_by_zero <= 1'b0;
        end
`endif
        DONE: begin
          if (zero_pend_reg) begin
            quotient      <= '1;
            remainder     <= a_raw_reg;
            div_by_zero   <= 1'b1;
            zero_pend_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus randomized operands
// with random output back-pressure, checked against an arithmetic reference model.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op_signed = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  logic rand_ready = 1'b0;
  logic rnd_ready = 1'b1;
  logic dir_ready = 1'b1;
  assign out_ready = rand_ready ? rnd_ready : dir_ready;

  int vectors = 0;
  int errors = 0;
  int pushed = 0;
  int outputs = 0;
  t_div_result exp_q[$];

  seq_divider #(.DATA_LEN(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op_signed  (op_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic t_div_result ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input bit sg);
    t_div_result r;
    longint sx, sy, sq, sr;
    if (y == 0) begin
      r.quotient = '1;
      r.remainder = x;
      r.div_by_zero = 1'b1;
    end else if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sq = sx / sy;
      sr = sx % sy;
      r.quotient = sq[W-1:0];
      r.remainder = sr[W-1:0];
      r.div_by_zero = 1'b0;
    end else begin
      r.quotient = x / y;
      r.remainder = x % y;
      r.div_by_zero = 1'b0;
    end
    return r;
  endfunction

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    t_div_result e;
    e.quotient = q;
    e.remainder = r;
    e.div_by_zero = z;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    t_div_result e;
    if (!reset && out_valid && out_ready) begin
      outputs++;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_output: got q=%0h r=%0h with no pending op", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        check("quotient", quotient, e.quotient);
        check("remainder", remainder, e.remainder);
        check("div_by_zero", div_by_zero, e.div_by_zero);
      end
    end
  end

  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic sg);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_timeout", in_ready, 1'b1);
    a = aa;
    b = bb;
    op_signed = sg;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic directed(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic sg,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                          input int lat, input string name);
    int edges;
    push(q, r, z);
    send(aa, bb, sg);
    wait_valid(edges);
    check({name, "_latency"}, edges, lat);
    @(posedge clk);
    #1;
    check({name, "_in_ready_after"}, in_ready, 1'b1);
    $display("op %s: %0h / %0h signed=%0d latency=%0d", name, aa, bb, sg, edges);
  endtask

  initial begin
    int edges;
    bit seen;
    logic [W-1:0] ra, rb;
    logic rs;
    t_div_result e;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_div_by_zero", div_by_zero, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    directed(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32, "100div7");
    directed(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, "5div0");

    // Back-pressure: result held, no second accept while in DONE.
    dir_ready = 1'b0;
    push(32'hFFFF_FFFF, 32'd0, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_valid(edges);
    check("stall_latency", edges, 32);
    for (int i = 0; i < 10; i++) begin
      a = 32'd9;
      b = 32'd3;
      in_valid = 1'b1;
      check("stall_quotient", quotient, 32'hFFFF_FFFF);
      check("stall_remainder", remainder, 32'd0);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    dir_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_in_ready", in_ready, 1'b1);
    $display("op stall: ffffffff / 1 held 10 cycles, 9/3 offered");

    // Reset mid-calculation discards the op.
    send(32'd50, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("midrst_no_output", seen, 1'b0);
    $display("op midreset: 50 / 5 discarded");
    directed(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 32, "9div4");

`ifdef SEQ_DIVIDER_SIGNED_EN
    directed(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "s_m7div2");
    directed(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, "s_mindivm1");
    directed(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, "s_m7div0");
    directed(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 32, "u_m7div2");
`else
    directed(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 32, "ign_m7div2");
`endif

    // Random operands with random output stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
      case ($urandom_range(0, 15))
        0:       rb = '0;
        1, 2, 3: rb = $urandom_range(1, 255);
        4:       rb = 32'd1;
        default: rb = $urandom;
      endcase
      rs = $urandom_range(0, 1);
      e = ref_div(ra, rb, rs & SIGNED_EN);
      push(e.quotient, e.remainder, e.div_by_zero);
      send(ra, rb, rs);
      if (i % 100 == 0) $display("op rand%0d: %0h / %0h signed=%0d", i, ra, rb, rs);
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);
    check("one_output_per_input", outputs, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
